fir_tap_sequencer: RTL

Sequential single-multiplier FIR engine controller for the FIR filter datapath. It accepts one signed sample per handshake and stores it in a circular history buffer. It then walks all taps, issuing coefficient addresses, multiplying each coefficient by the matching history sample, sign-extending each product to accumulator width and accumulating. When the walk finishes it presents the filtered result with a one-cycle valid pulse. It sits between the sample source and the output register stage; coefficients come from an external registered ROM.

---
 rtl/fir_tap_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: single-multiplier FIR controller walking TAPS coefficients per accepted sample
module fir_tap_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int TAPS       = 64,
   parameter int ACC_WIDTH  = 38
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic [$clog2(TAPS)-1:0]      coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output logic                         out_valid,
   output logic signed [ACC_WIDTH-1:0]  out_data
);
   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_WIDTH + COEF_WIDTH;
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t state, state_nx;
   logic [AW:0] k;
   logic [AW-1:0] wr_ptr, newest;
   logic signed [DATA_WIDTH-1:0] hist [TAPS];
   logic signed [DATA_WIDTH-1:0] smp;
   logic signed [PW-1:0] prod;
   logic signed [ACC_WIDTH-1:0] acc, acc_sum;
   logic accept, last;
   assign accept = in_valid && in_ready && !flush;
   assign last = (state == MAC) && k[AW];
   assign prod = coef_data * smp;
   assign acc_sum = acc + ACC_WIDTH'(prod);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = flush ? IDLE : accept ? MAC : last ? DONE : (state == DONE) ? IDLE : state;
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == DONE;
      coef_addr = (state == MAC && !k[AW]) ? k[AW-1:0] : '0;
   end
   // k counts issue cycles 0..TAPS-1 then the drain cycle TAPS; each add uses the previous cycle's sample and ROM word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         newest <= '0;
         k <= '0;
         smp <= '0;
         acc <= '0;
         out_data <= '0;
         for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         k <= '0;
         acc <= '0;
         for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      end else begin
         if (accept) begin
            hist[wr_ptr] <= in_data;
            newest <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(1);
            acc <= '0;
            k <= '0;
         end
         if (state == MAC) begin
            smp <= hist[newest - k[AW-1:0]];
            k <= k + (AW+1)'(1);
            if (k != '0) acc <= acc_sum;
            if (last) out_data <= acc_sum;
         end
      end
endmodule
